// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/interrupt sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SLEEP = 2'd1,
        WAKE  = 2'd2
    } pc_state_e;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    // mepc is only meaningful while a trap is being taken; park it at zero otherwise.
    function automatic logic [31:0] trap_pc(input logic take, input logic [31:0] pc);
        return take ? pc : ZeroWord;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Event inputs from the pipeline and per-stage control outputs of pipe_ctrl.
interface pipe_ctrl_if;
    logic        im_wait;
    logic        dm_wait;
    logic        load_use;
    logic        branch_taken_EX;
    logic        wfi_EX;
    logic        mret_EX;
    logic        ext_irq;
    logic        mstatus_mie;
    logic        mie_meie;
    logic [31:0] pc_EX;

    logic        stall_pc;
    logic        stall_IFID;
    logic        stall_IDEX;
    logic        stall_EXMEM;
    logic        stall_MEMWB;
    logic        flush_IFID;
    logic        flush_IDEX;
    logic        WFI;
    logic        interrupt_pulse;
    logic        trap_take;
    logic [31:0] mepc_o;
    logic        mret_take;

    modport master (
        output im_wait, dm_wait, load_use, branch_taken_EX, wfi_EX, mret_EX,
               ext_irq, mstatus_mie, mie_meie, pc_EX,
        input  stall_pc, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB,
               flush_IFID, flush_IDEX, WFI, interrupt_pulse, trap_take,
               mepc_o, mret_take
    );

    modport slave (
        input  im_wait, dm_wait, load_use, branch_taken_EX, wfi_EX, mret_EX,
               ext_irq, mstatus_mie, mie_meie, pc_EX,
        output stall_pc, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB,
               flush_IFID, flush_IDEX, WFI, interrupt_pulse, trap_take,
               mepc_o, mret_take
    );
endinterface

// File: rtl/pipe_ctrl_irq_sync.sv
// Flop-chain synchronizer bringing the asynchronous external interrupt into clk.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    // Fewer than two flops does not give metastability protection.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush and WFI/interrupt sequencer for the 5-stage core.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);

    logic      irq_sync_s;
    logic      irq_pend;
    logic      irq_take;
    logic      mem_wait;
    pc_state_e state_q, state_d;
    logic      wfi_q;

    logic stall_pc_c, stall_ifid_c, stall_idex_c, stall_exmem_c, stall_memwb_c;
    logic flush_ifid_c, flush_idex_c;
    logic pulse_c, trap_c, mret_c;

    irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.ext_irq),
        .q_o (irq_sync_s)
    );

    assign irq_pend = irq_sync_s & bus.mie_meie;
    assign irq_take = irq_pend & bus.mstatus_mie;
    assign mem_wait = bus.im_wait | bus.dm_wait;

    always_comb begin
        state_d       = state_q;
        stall_pc_c    = 1'b0;
        stall_ifid_c  = 1'b0;
        stall_idex_c  = 1'b0;
        stall_exmem_c = 1'b0;
        stall_memwb_c = 1'b0;
        flush_ifid_c  = 1'b0;
        flush_idex_c  = 1'b0;
        pulse_c       = 1'b0;
        trap_c        = 1'b0;
        mret_c        = 1'b0;

        // Outputs are combinational, so they must be forced low while reset is held.
        if (rst) begin
            case (state_q)
                RUN, WAKE: begin
                    state_d = RUN;
                    if (mem_wait) begin
                        // A wait freezes everything; a pending trap is retried afterwards.
                        state_d       = state_q;
                        stall_pc_c    = 1'b1;
                        stall_ifid_c  = 1'b1;
                        stall_idex_c  = 1'b1;
                        stall_exmem_c = 1'b1;
                        stall_memwb_c = 1'b1;
                    end else if (irq_take) begin
                        trap_c        = 1'b1;
                        flush_ifid_c  = 1'b1;
                        flush_idex_c  = 1'b1;
                        stall_exmem_c = 1'b1;
                    end else if (bus.mret_EX) begin
                        mret_c       = 1'b1;
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                    end else if (bus.wfi_EX) begin
                        // With an interrupt already pending, WFI retires as a NOP.
                        if (!irq_pend) begin
                            state_d = SLEEP;
                        end
                    end else if (bus.branch_taken_EX) begin
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                    end else if (bus.load_use) begin
                        stall_pc_c   = 1'b1;
                        stall_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                    end
                end
                SLEEP: begin
                    stall_pc_c    = 1'b1;
                    stall_ifid_c  = 1'b1;
                    stall_idex_c  = 1'b1;
                    stall_exmem_c = 1'b1;
                    stall_memwb_c = 1'b1;
                    // Wake on pending regardless of global enable; the trap decision is made in WAKE.
                    if (irq_pend) begin
                        pulse_c = 1'b1;
                        state_d = WAKE;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wfi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wfi_q   <= (state_d == SLEEP);
        end
    end

    assign bus.stall_pc        = stall_pc_c;
    assign bus.stall_IFID      = stall_ifid_c;
    assign bus.stall_IDEX      = stall_idex_c;
    assign bus.stall_EXMEM     = stall_exmem_c;
    assign bus.stall_MEMWB     = stall_memwb_c;
    assign bus.flush_IFID      = flush_ifid_c;
    assign bus.flush_IDEX      = flush_idex_c;
    assign bus.WFI             = wfi_q;
    assign bus.interrupt_pulse = pulse_c;
    assign bus.trap_take       = trap_c;
    assign bus.mret_take       = mret_c;
    assign bus.mepc_o          = trap_pc(trap_c, bus.pc_EX);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl.
module tb_pipe_ctrl;
    logic clk;
    logic rst;

    pipe_ctrl_if bus();

    pipe_ctrl #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [10:0] ctl;
        logic [31:0] mepc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // {stall_pc,IFID,IDEX,EXMEM,MEMWB, flush_IFID,IDEX, WFI, pulse, trap, mret}
    localparam logic [10:0] NONE   = 11'b00000_00_0_0_0_0;
    localparam logic [10:0] ALLSTL = 11'b11111_00_0_0_0_0;
    localparam logic [10:0] LU     = 11'b11000_01_0_0_0_0;
    localparam logic [10:0] BR     = 11'b00000_11_0_0_0_0;
    localparam logic [10:0] TRAP   = 11'b00010_11_0_0_1_0;
    localparam logic [10:0] MRET   = 11'b00000_11_0_0_0_1;
    localparam logic [10:0] SLP    = 11'b11111_00_1_0_0_0;
    localparam logic [10:0] SLPPLS = 11'b11111_00_1_1_0_0;

    function automatic logic [42:0] observed();
        return {bus.stall_pc, bus.stall_IFID, bus.stall_IDEX, bus.stall_EXMEM,
                bus.stall_MEMWB, bus.flush_IFID, bus.flush_IDEX, bus.WFI,
                bus.interrupt_pulse, bus.trap_take, bus.mret_take, bus.mepc_o};
    endfunction

    // Push the expectation for the current cycle, sample mid-cycle, then move past the next edge.
    task automatic cyc(input string tag, input logic [10:0] ctl, input logic [31:0] mepc);
        exp_t e;
        logic [42:0] obs;
        q.push_back('{tag: tag, ctl: ctl, mepc: mepc});
        @(negedge clk);
        e   = q.pop_front();
        obs = observed();
        total++;
        assert (obs === {e.ctl, e.mepc})
        else begin
            bad++;
            $error("FAIL %s: observed ctl=%b mepc=%h expected ctl=%b mepc=%h",
                   e.tag, obs[42:32], obs[31:0], e.ctl, e.mepc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                 = 1'b0;
        bus.im_wait         = 1'b0;
        bus.dm_wait         = 1'b0;
        bus.load_use        = 1'b0;
        bus.branch_taken_EX = 1'b0;
        bus.wfi_EX          = 1'b0;
        bus.mret_EX         = 1'b0;
        bus.ext_irq         = 1'b0;
        bus.mstatus_mie     = 1'b0;
        bus.mie_meie        = 1'b1;
        bus.pc_EX           = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        bus.load_use = 1'b1;
        cyc("reset_hold", NONE, 32'h0);
        bus.load_use = 1'b0;
        rst = 1'b1;

        cyc("idle", NONE, 32'h0);
        bus.load_use = 1'b1;
        cyc("load_use", LU, 32'h0);
        bus.load_use = 1'b0;
        cyc("load_use_end", NONE, 32'h0);

        bus.load_use = 1'b1; bus.branch_taken_EX = 1'b1;
        cyc("branch_over_lu", BR, 32'h0);
        bus.load_use = 1'b0; bus.branch_taken_EX = 1'b0;

        bus.mret_EX = 1'b1;
        cyc("mret", MRET, 32'h0);
        bus.branch_taken_EX = 1'b1;
        cyc("mret_over_branch", MRET, 32'h0);
        bus.mret_EX = 1'b0;
        bus.im_wait = 1'b1;
        cyc("im_wait_over_branch", ALLSTL, 32'h0);
        bus.im_wait = 1'b0; bus.branch_taken_EX = 1'b0;

        // WFI sleep, wake without global enable
        bus.wfi_EX = 1'b1;
        cyc("wfi_commit", NONE, 32'h0);
        bus.wfi_EX = 1'b0; bus.ext_irq = 1'b1;
        cyc("sleep_1", SLP, 32'h0);
        cyc("sleep_2", SLP, 32'h0);
        cyc("wake_pulse", SLPPLS, 32'h0);
        cyc("wake_no_trap", NONE, 32'h0);
        bus.ext_irq = 1'b0;
        cyc("run_after_wake_a", NONE, 32'h0);
        cyc("run_after_wake_b", NONE, 32'h0);

        // WFI sleep, wake into trap
        bus.pc_EX = 32'h0000_0100; bus.mstatus_mie = 1'b1;
        bus.wfi_EX = 1'b1;
        cyc("wfi2_commit", NONE, 32'h0);
        bus.wfi_EX = 1'b0; bus.ext_irq = 1'b1;
        cyc("sleep2_1", SLP, 32'h0);
        cyc("sleep2_2", SLP, 32'h0);
        cyc("wake2_pulse", SLPPLS, 32'h0);
        cyc("wake2_trap", TRAP, 32'h0000_0100);
        bus.mstatus_mie = 1'b0; bus.ext_irq = 1'b0;
        cyc("post_trap_a", NONE, 32'h0);
        cyc("post_trap_b", NONE, 32'h0);

        // WFI with an interrupt already pending is a NOP
        bus.ext_irq = 1'b1;
        cyc("pend_fill_a", NONE, 32'h0);
        cyc("pend_fill_b", NONE, 32'h0);
        bus.wfi_EX = 1'b1;
        cyc("wfi_nop", NONE, 32'h0);
        bus.wfi_EX = 1'b0;
        cyc("wfi_nop_stays_run", NONE, 32'h0);

        // Memory wait defers a trap
        bus.pc_EX = 32'h0000_0200; bus.mstatus_mie = 1'b1; bus.dm_wait = 1'b1;
        cyc("dm_wait_defer_1", ALLSTL, 32'h0);
        cyc("dm_wait_defer_2", ALLSTL, 32'h0);
        cyc("dm_wait_defer_3", ALLSTL, 32'h0);
        bus.dm_wait = 1'b0;
        cyc("deferred_trap", TRAP, 32'h0000_0200);
        bus.mstatus_mie = 1'b0; bus.ext_irq = 1'b0;
        cyc("post_trap2_a", NONE, 32'h0);
        cyc("post_trap2_b", NONE, 32'h0);

        // Reset while asleep
        bus.wfi_EX = 1'b1;
        cyc("wfi3_commit", NONE, 32'h0);
        bus.wfi_EX = 1'b0;
        cyc("sleep3", SLP, 32'h0);
        rst = 1'b0;
        cyc("reset_in_sleep", NONE, 32'h0);
        rst = 1'b1;
        cyc("after_reset_run", NONE, 32'h0);
        bus.load_use = 1'b1;
        cyc("after_reset_lu", LU, 32'h0);
        bus.load_use = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
